// File: rtl/vector_lsu.sv
// vector_lsu: moves 6-lane vectors or single bytes between the
// byte-wide data memory and the vector register file write port.
module vector_lsu #(
  parameter int LANES  = 6,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic                    sflag,
  input  logic [3:0]              reg_idx,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    WE3,
  output logic [3:0]              A3,
  output logic [LANES*DATA_W-1:0] WD3,
  output logic                    SFlag,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int IW = $clog2(LANES);
  localparam logic [3:0] LANES4 = 4'(LANES);

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LWAIT,
    S_WB,
    S_STORE,
    S_FIN
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_i;
  vec_t              r_buf;
  vec_t              r_sdata;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_reg;
  logic              r_sflag;
  logic              r_errp;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_we3;
  logic [3:0]        r_a3;
  vec_t              r_wd3;
  logic              r_sf_o;
  logic              r_done;
  logic              r_err;

  vec_t              w_sd_in;
  vec_t              w_buf_cap;
  logic [IW-1:0]     w_last;
  logic [IW-1:0]     w_inext;
  logic [IW-1:0]     w_cap_lane;
  logic [IW-1:0]     w_acc_lane;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_err_cmd;

  assign w_sd_in     = store_data;
  assign w_last      = r_sflag ? '0 : IW'(LANES - 1);
  assign w_inext     = r_i + IW'(1);
  assign w_addr_next = r_base + ADDR_W'(w_inext);
  assign w_acc_lane  = sflag ? reg_idx[IW-1:0] : '0;
  assign w_err_cmd   = sflag && (reg_idx >= LANES4);

  // Byte returned for issue k lands one cycle later, so LOAD
  // captures lane i-1 and LWAIT captures the final lane i.
  assign w_cap_lane =
    (r_state == S_LOAD && r_i != '0) ? r_i - IW'(1) : r_i;

  // Lane buffer with the byte arriving this cycle merged in
  always_comb begin
    w_buf_cap = r_buf;
    w_buf_cap[w_cap_lane] = mem_rdata;
  end

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign WE3       = r_we3;
  assign A3        = r_a3;
  assign WD3       = r_wd3;
  assign SFlag     = r_sf_o;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);

  // Command FSM; outputs are registered for the cycle being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_buf       <= '0;
      r_sdata     <= '0;
      r_base      <= '0;
      r_reg       <= '0;
      r_sflag     <= 1'b0;
      r_errp      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_we3       <= 1'b0;
      r_a3        <= '0;
      r_wd3       <= '0;
      r_sf_o      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_we3       <= 1'b0;
      r_a3        <= '0;
      r_wd3       <= '0;
      r_sf_o      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sdata <= w_sd_in;
            r_base  <= base_addr;
            r_reg   <= reg_idx;
            r_sflag <= sflag;
            r_i     <= '0;
            r_errp  <= w_err_cmd;
            if (w_err_cmd) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (is_store) begin
              r_state     <= S_STORE;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= base_addr;
              r_mem_wdata <= w_sd_in[w_acc_lane];
            end else begin
              r_state    <= S_LOAD;
              r_buf      <= '0;
              r_mem_addr <= base_addr;
            end
          end
        end
        S_LOAD: begin
          if (r_i != '0) r_buf <= w_buf_cap;
          if (r_i == w_last) begin
            r_state <= S_LWAIT;
          end else begin
            r_i        <= w_inext;
            r_mem_addr <= w_addr_next;
          end
        end
        S_LWAIT: begin
          r_buf   <= w_buf_cap;
          r_state <= S_WB;
          r_we3   <= 1'b1;
          r_a3    <= r_reg;
          r_sf_o  <= r_sflag;
          r_wd3   <= w_buf_cap;
          r_done  <= 1'b1;
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        S_STORE: begin
          if (r_i == w_last) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_err   <= r_errp;
          end else begin
            r_i         <= w_inext;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_addr_next;
            r_mem_wdata <= r_sdata[w_inext];
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_errp  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// tb_vector_lsu: directed vectors against a byte memory model
// attached to vector_lsu.
module tb_vector_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic        sflag;
  logic [3:0]  reg_idx;
  logic [15:0] base_addr;
  logic [47:0] store_data;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        WE3;
  logic [3:0]  A3;
  logic [47:0] WD3;
  logic        SFlag;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  vector_lsu dut (
    .clk(clk), .rst(rst), .start(start),
    .is_store(is_store), .sflag(sflag),
    .reg_idx(reg_idx), .base_addr(base_addr),
    .store_data(store_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .WE3(WE3), .A3(A3),
    .WD3(WD3), .SFlag(SFlag), .busy(busy),
    .done(done), .err(err)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drives one start pulse; returns at the negedge of cycle T+1
  task automatic issue(input logic st, input logic sf,
                       input logic [3:0] ri,
                       input logic [15:0] ba,
                       input logic [47:0] sd);
    @(negedge clk);
    is_store   = st;
    sflag      = sf;
    reg_idx    = ri;
    base_addr  = ba;
    store_data = sd;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic bad;
  logic [15:0] exp_a [0:5];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int k = 0; k < 6; k++) mem[16'h0100 + k] = 8'h10 + 8'(k);
    mem[16'h0020] = 8'hAB;
    mem[16'h0021] = 8'hFF;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; sflag = 1'b0;
    reg_idx = '0; base_addr = '0; store_data = '0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_outs",
          {mem_addr, mem_we, mem_wdata, WE3, A3, SFlag, done, err},
          0);
    check("rst_wd3", WD3, 0);
    rst = 1'b0;

    // Vector load, with start held high while busy and in done cycle
    issue(1'b0, 1'b0, 4'd7, 16'h0100, 48'h0);
    check("vl_busy_t1", busy, 1);
    bad = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 6 && mem_addr !== 16'h0100 + 16'(k - 1)) bad = 1'b1;
      if (WE3 || done || mem_we) bad = 1'b1;
      if (k == 1) begin
        start = 1'b1; is_store = 1'b1; sflag = 1'b1; reg_idx = 4'd9;
      end
      step();
    end
    check("vl_issue_seq", bad, 0);
    check("vl_we3", WE3, 1);
    check("vl_a3", A3, 7);
    check("vl_sflag", SFlag, 0);
    check("vl_wd3", WD3, 48'h151413121110);
    check("vl_done", {done, err, busy}, 3'b101);
    step();
    check("vl_ignored_start", {busy, done, WE3}, 3'b000);
    start = 1'b0;

    // Scalar load
    issue(1'b0, 1'b1, 4'd3, 16'h0020, 48'h0);
    check("sl_addr", mem_addr, 16'h0020);
    step();
    check("sl_t2_quiet", {WE3, done}, 2'b00);
    step();
    check("sl_we3", {WE3, SFlag, A3}, {1'b1, 1'b1, 4'd3});
    check("sl_wd3", WD3, 48'h0000000000AB);
    check("sl_done", done, 1);

    // Vector store across the address wrap
    exp_a = '{16'hFFFD, 16'hFFFE, 16'hFFFF,
              16'h0000, 16'h0001, 16'h0002};
    step();
    issue(1'b1, 1'b0, 4'd0, 16'hFFFD, 48'h060504030201);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!mem_we || mem_addr !== exp_a[k] ||
          mem_wdata !== 8'(k + 1) || WE3 || done) bad = 1'b1;
      step();
    end
    check("vs_writes", bad, 0);
    check("vs_done", {done, err, mem_we, WE3}, 4'b1000);
    check("vs_mem_wrap", {mem[16'hFFFF], mem[16'h0000]},
          16'h0304);

    // Scalar store from lane 4
    step();
    issue(1'b1, 1'b1, 4'd4, 16'h0040, 48'hAA5C44332211);
    check("ss_write", {mem_we, mem_addr, mem_wdata},
          {1'b1, 16'h0040, 8'h5C});
    step();
    check("ss_done", {done, mem_we, WE3, busy}, 4'b1001);
    step();
    check("ss_idle", busy, 0);

    // Error command
    issue(1'b0, 1'b1, 4'd9, 16'h0200, 48'h0);
    check("er_done", {done, err, mem_we, WE3}, 4'b1100);
    step();
    check("er_idle", {busy, done, err}, 3'b000);

    // Reset at T+3 of a vector load
    issue(1'b0, 1'b0, 4'd2, 16'h0100, 48'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ra_busy", busy, 0);
    check("ra_outs", {mem_addr, mem_we, WE3, done, A3}, 0);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (WE3 || done || busy) bad = 1'b1;
      step();
    end
    check("ra_no_wb", bad, 0);
    issue(1'b0, 1'b1, 4'd1, 16'h0020, 48'h0);
    step();
    step();
    check("ra_new_cmd", {WE3, A3, done}, {1'b1, 4'd1, 1'b1});
    check("ra_new_wd3", WD3, 48'h0000000000AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
